pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 141 ++++++++++++++
 tb/tb_pc_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: selects the next fetch address from sequential,
// branch, jump, register-jump and return-address-stack sources.
module pc_sequencer #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(32'h0000_3000),
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch,
  input  logic              branch_cond,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic              link,
  input  logic              ret,
  input  logic [15:0]       imm16,
  input  logic [25:0]       target,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_pc,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              misalign
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  // Pointer wraps explicitly so non-power-of-two depths stay in range.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_MAX : p - 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? CNT_MAX : c + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

  logic [ADDR_W-1:0]        ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]         ptr;
  logic [PTR_W-1:0]         ptr_nxt;
  logic [PTR_W-1:0]         top_idx;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         count_nxt;
  logic [ADDR_W-1:0]        ras_top;
  logic [ADDR_W-1:0]        seq;
  logic signed [15:0]       imm_s;
  logic signed [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0]        br_tgt;
  logic [ADDR_W-1:0]        j_tgt;
  logic [ADDR_W-1:0]        r_tgt;
  logic                     pop_sel;
  logic                     push;
  logic                     pop;

  assign imm_s   = imm16;
  assign br_off  = {{(ADDR_W - 18){imm_s[15]}}, imm_s, 2'b00};
  assign seq     = pc + ADDR_W'(4);
  assign br_tgt  = seq + $unsigned(br_off);
  assign j_tgt   = {seq[ADDR_W-1:28], target, 2'b00};
  assign r_tgt   = {reg_target[ADDR_W-1:2], 2'b00};

  // ptr names the next free slot; the top of stack sits just below it.
  assign top_idx = ptr_dec(ptr);
  assign ras_top = ras_mem[top_idx];

  // An empty stack never selects RAS, so stale entries stay invisible.
  assign pop_sel = ret & ~ras_empty;
  assign push    = link & (jump | jump_reg) & ~stall;
  assign pop     = pop_sel & ~stall;

  always_comb begin
    next_pc  = seq;
    misalign = 1'b0;
    if (pop_sel) begin
      next_pc = ras_top;
    end else if (jump_reg) begin
      next_pc  = r_tgt;
      misalign = |reg_target[1:0];
    end else if (jump) begin
      next_pc = j_tgt;
    end else if (branch && branch_cond) begin
      next_pc = br_tgt;
    end
  end

  // Simultaneous push and pop rewrites the top in place.
  always_comb begin
    ptr_nxt   = ptr;
    count_nxt = count;
    case ({push, pop})
      2'b10: begin
        ptr_nxt   = ptr_inc(ptr);
        count_nxt = cnt_sat_inc(count);
      end
      2'b01: begin
        ptr_nxt   = ptr_dec(ptr);
        count_nxt = cnt_sat_dec(count);
      end
      default: begin
        ptr_nxt   = ptr;
        count_nxt = count;
      end
    endcase
  end

  // ---- control registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      ptr       <= '0;
      count     <= '0;
      ras_empty <= 1'b1;
      ras_full  <= 1'b0;
    end else if (!stall) begin
      pc        <= next_pc;
      ptr       <= ptr_nxt;
      count     <= count_nxt;
      ras_empty <= (count_nxt == '0);
      ras_full  <= (count_nxt == CNT_MAX);
    end
  end

  // ---- return-address storage ----
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      ras_mem[pop ? top_idx : ptr] <= seq;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected addresses.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch;
  logic        branch_cond;
  logic        jump;
  logic        jump_reg;
  logic        link;
  logic        ret;
  logic [15:0] imm16;
  logic [25:0] target;
  logic [31:0] reg_target;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        ras_empty;
  logic        ras_full;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch),
    .branch_cond(branch_cond), .jump(jump), .jump_reg(jump_reg),
    .link(link), .ret(ret), .imm16(imm16), .target(target),
    .reg_target(reg_target), .pc(pc), .next_pc(next_pc),
    .ras_empty(ras_empty), .ras_full(ras_full), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    stall = 0; branch = 0; branch_cond = 0; jump = 0; jump_reg = 0;
    link = 0; ret = 0; imm16 = '0; target = '0; reg_target = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_addr(input logic [31:0] a);
    idle();
    jump_reg = 1; reg_target = a;
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    check("rst_pc", pc, 32'h3000);
    check("rst_empty", ras_empty, 1);
    check("rst_full", ras_full, 0);
    check("rst_next", next_pc, 32'h3004);

    tick(); check("seq1", pc, 32'h3004);
    tick(); check("seq2", pc, 32'h3008);
    tick(); check("seq3", pc, 32'h300C);

    // Branch taken / not taken, then wrap across 2^32
    goto_addr(32'h3010);
    check("goto_3010", pc, 32'h3010);
    branch = 1; branch_cond = 1; imm16 = 16'hFFFC; #1;
    check("br_back", next_pc, 32'h3004);
    branch_cond = 0; #1;
    check("br_not", next_pc, 32'h3014);
    goto_addr(32'hFFFF_FFF0);
    branch = 1; branch_cond = 1; imm16 = 16'h7FFF; #1;
    check("br_wrap", next_pc, 32'h0001_FFF0);
    branch_cond = 0; #1;
    check("seq_wrap", next_pc, 32'hFFFF_FFF4);

    // Reset while a call is pending discards it
    jump = 1; link = 1; target = 26'h100; rst = 1;
    tick();
    rst = 0; idle(); #1;
    check("midrst_pc", pc, 32'h3000);
    check("midrst_empty", ras_empty, 1);

    // Call and return
    jump = 1; link = 1; target = 26'h100; #1;
    check("call_next", next_pc, 32'h0000_0400);
    tick(); idle(); #1;
    check("call_pc", pc, 32'h0000_0400);
    check("call_empty", ras_empty, 0);

    // Stall holds PC and RAS while next_pc still shows the jump target
    stall = 1; jump = 1; link = 1; target = 26'h200; #1;
    check("stall_next", next_pc, 32'h0000_0800);
    tick(); tick();
    check("stall_pc", pc, 32'h0000_0400);
    check("stall_empty", ras_empty, 0);
    idle(); ret = 1; #1;
    check("ret_next", next_pc, 32'h3004);
    tick(); idle(); #1;
    check("ret_pc", pc, 32'h3004);
    check("ret_empty", ras_empty, 1);

    // Return hint with empty stack falls through
    ret = 1; #1;
    check("ret_empty_fall", next_pc, 32'h3008);
    idle();

    // Push and pop in one cycle replaces the top
    jump = 1; link = 1; target = 26'h100;
    tick(); idle();
    check("pp_setup_pc", pc, 32'h400);
    ret = 1; jump = 1; link = 1; target = 26'h300; #1;
    check("pp_next", next_pc, 32'h3008);
    tick(); idle(); #1;
    check("pp_pc", pc, 32'h3008);
    check("pp_empty", ras_empty, 0);
    ret = 1; #1;
    check("pp_top", next_pc, 32'h404);
    tick(); idle(); #1;
    check("pp_drained", ras_empty, 1);

    // Five calls into a four-deep stack
    goto_addr(32'h100);
    for (int i = 1; i <= 5; i++) begin
      jump_reg = 1; link = 1; reg_target = 32'((i + 1) * 32'h100);
      tick(); idle();
      if (i == 3) check("ovf_full3", ras_full, 0);
      if (i >= 4) check($sformatf("ovf_full%0d", i), ras_full, 1);
    end
    check("ovf_pc", pc, 32'h600);
    for (int k = 0; k < 4; k++) begin
      ret = 1; reg_target = 32'h800; #1;
      check($sformatf("ovf_ret%0d", k), next_pc, 32'h504 - 32'(k) * 32'h100);
      tick(); idle();
    end
    check("ovf_empty", ras_empty, 1);
    check("ovf_notfull", ras_full, 0);
    ret = 1; jump_reg = 1; reg_target = 32'h800; #1;
    check("ovf_ret5", next_pc, 32'h800);
    check("ovf_ret5_mis", misalign, 0);

    // Register jump alignment and priority over jump
    idle(); jump_reg = 1; reg_target = 32'h0000_4006; #1;
    check("jr_next", next_pc, 32'h4004);
    check("jr_mis", misalign, 1);
    jump = 1; target = 26'h3FF; #1;
    check("jr_prio", next_pc, 32'h4004);
    check("jr_prio_mis", misalign, 1);
    jump_reg = 0; #1;
    check("j_only_mis", misalign, 0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
